cdc_handshake_receiver: RTL
===========================

// Module: cdc_handshake_receiver
// PURPOSE
//   Destination end of a 4-phase req/ack CDC handshake. Runs entirely in dst_clk.
//   Synchronizes an incoming request, captures the bundled data held stable by the
//   source end, presents it as a valid/ready stream, and returns a level ack.
//   Sits between the CDC boundary and destination-domain consumers.
// PARAMETERS
//   DATA_WIDTH   32  width of bundled data and output payload
//   SYNC_STAGES  2   flops in the async_req synchronizer chain; legal values >= 2
//   COUNT_WIDTH  16  width of completed-transfer counter; wraps modulo 2^COUNT_WIDTH
// PORTS
//   dst_clk       in   1            destination clock; all logic on its rising edge
//   dst_rst_n     in   1            asynchronous active-low reset
//   async_req     in   1            request level from foreign domain; unsynchronized
//   async_data    in   DATA_WIDTH   bundled data; stable while async_req is high and ack is low
//   async_ack     out  1            registered ack level to foreign domain
//   dst_data      out  DATA_WIDTH   captured payload
//   dst_valid     out  1            payload valid
//   dst_ready     in   1            consumer accepts payload
//   protocol_err  out  1            one-cycle pulse on handshake violation
//   xfer_count    out  COUNT_WIDTH  count of accepted transfers
// BEHAVIOUR
//   Reset (async assert, sync release): sync chain=0, state=IDLE, async_ack=0, dst_valid=0,
//     dst_data=0, protocol_err=0, xfer_count=0. All outputs are registered.
//   req_s = last stage of the SYNC_STAGES chain sampling async_req. No other logic reads async_req.
//   async_data is sampled only in IDLE when req_s=1. It is never synchronized.
//   FSM:
//     IDLE:  if req_s=1, then dst_data<=async_data, dst_valid<=1, go VALID.
//     VALID: dst_valid held at 1. dst_data is stable.
//            On dst_ready=1: dst_valid<=0, async_ack<=1, xfer_count+=1, go ACK.
//            If req_s=0 in VALID: protocol_err pulses for 1 cycle. Stay in VALID.
//              The payload is still delivered.
//     ACK:   async_ack held at 1. When req_s=0: async_ack<=0, go IDLE.
//   Latency, with async_req stable high before sampling edge E0:
//     req_s=1 after edge E(SYNC_STAGES-1).
//     dst_valid=1 after edge E(SYNC_STAGES); SYNC_STAGES+1 edges total.
//   Accept at edge N (dst_valid&dst_ready): async_ack=1 after edge N. dst_valid=0 after edge N.
//   async_req low at sampling edge M: async_ack=0 after edge M+SYNC_STAGES.
//   Next capture needs IDLE and req_s=1. At most one transfer is in flight; no buffering.
//   Back-to-back: source raising req right after seeing ack low is legal and is captured normally.
//   dst_valid does not depend combinationally on dst_ready. dst_ready is ignored outside VALID.
//   xfer_count wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
//   Reset mid-transfer: everything returns to reset values. A still-high req_s after reset is
//     accepted as a new transfer (duplicate possible). Both ends are reset together system-wide.
//   X on async_data outside the capture cycle never propagates to dst_data.
// TESTING
//   Single transfer: SYNC_STAGES=2, async_data=32'hDEADBEEF, raise req, dst_ready=1
//     -> dst_valid on 3rd edge, dst_data=32'hDEADBEEF, ack=1 next cycle, xfer_count=1.
//   Backpressure: dst_ready=0 for 10 cycles -> dst_valid and dst_data stable, async_ack=0
//     throughout. Ready=1 -> one accept, ack rises.
//   Back-to-back: 8 transfers 0x1..0x8 with free-running dst_ready=1
//     -> 8 in-order payloads, no duplicates, xfer_count=8.
//   Protocol error: drop async_req while in VALID -> protocol_err 1-cycle pulse, payload still
//     delivered, ack rises on accept.
//   Reset mid-transfer: assert dst_rst_n=0 in ACK state -> async_ack, dst_valid, xfer_count=0
//     immediately, state IDLE.
//   Counter wrap: COUNT_WIDTH=4, 17 transfers -> xfer_count=1.

Source files
------------

// File: rtl/cdc_handshake_receiver_if.sv
// Signal bundle between the foreign-domain handshake source, the receiver and
// the destination-domain stream consumer.
interface cdc_handshake_receiver_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   async_req;
  logic [DATA_WIDTH-1:0]  async_data;
  logic                   async_ack;
  logic [DATA_WIDTH-1:0]  dst_data;
  logic                   dst_valid;
  logic                   dst_ready;
  logic                   protocol_err;
  logic [COUNT_WIDTH-1:0] xfer_count;

  // Environment side: issues requests and consumes the payload stream.
  modport master (
    output async_req,
    output async_data,
    output dst_ready,
    input  async_ack,
    input  dst_data,
    input  dst_valid,
    input  protocol_err,
    input  xfer_count
  );

  // Receiver side.
  modport slave (
    input  async_req,
    input  async_data,
    input  dst_ready,
    output async_ack,
    output dst_data,
    output dst_valid,
    output protocol_err,
    output xfer_count
  );
endinterface

// File: rtl/cdc_handshake_receiver.sv
// Destination end of a 4-phase req/ack handshake: synchronizes the request,
// captures the bundled data, offers it as valid/ready and returns a level ack.
module cdc_handshake_receiver #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    dst_clk,
  input  logic                    dst_rst_n,
  cdc_handshake_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   err_seen_q, err_seen_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // async_req enters only through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.async_req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ack_d      = ack_q;
    err_d      = 1'b0;
    err_seen_d = err_seen_q;
    count_d    = count_q;

    unique case (state_q)
      ST_IDLE: begin
        // async_data is only looked at here, once req_s proves it is stable.
        if (req_s) begin
          data_d     = bus.async_data;
          valid_d    = 1'b1;
          err_seen_d = 1'b0;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        // An early request drop is flagged once per transfer; the payload still goes out.
        if (!req_s && !err_seen_q) begin
          err_d      = 1'b1;
          err_seen_d = 1'b1;
        end
        if (bus.dst_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_seen_q <= err_seen_d;
      count_q    <= count_d;
    end
  end

  assign bus.async_ack    = ack_q;
  assign bus.dst_data     = data_q;
  assign bus.dst_valid    = valid_q;
  assign bus.protocol_err = err_q;
  assign bus.xfer_count   = count_q;

endmodule
